// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: data word, RAM handshake states and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  localparam word_t WORD_ZERO = 32'h0000_0000;

  // Only ACCESS completes a transfer; ERROR is deliberately treated like BUSY.
  function automatic logic ram_done(input logic [1:0] st);
    return ramstate_t'(st) == ACCESS;
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// arb_timer: grant watchdog counter for mem_arbiter, only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module arb_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count non-completing grant cycles, saturating at the limit until cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (data over instruction) arbiter onto a single RAM port.
// Optional grant watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout_err
);

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  logic       access_s;
  logic       dreq_s;
  logic       expired_s;

  assign access_s = ram_done(ramstate);
  assign dreq_s   = dREN | dWEN;

`ifdef MEM_ARB_TIMEOUT_EN
  arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .en      ((state_r != IDLE) && !access_s),
    .clr     (state_r == IDLE),
    .expired (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // Next-state and RAM/requester outputs; a dropped request aborts before completion is considered.
  always_comb begin
    state_nxt_s = state_r;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = WORD_ZERO;
    dload       = WORD_ZERO;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = WORD_ZERO;
    ramstore    = WORD_ZERO;
    timeout_err = 1'b0;
    case (state_r)
      IDLE: begin
        if (dreq_s) begin
          state_nxt_s = DGRANT;
        end else if (iREN) begin
          state_nxt_s = IGRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (dWEN) begin
          ramWEN = 1'b1;
          ramREN = 1'b0;
        end else begin
          ramWEN = 1'b0;
          ramREN = dREN;
        end
        if (!dreq_s) begin
          state_nxt_s = IDLE;
        end else if (access_s) begin
          dwait       = 1'b0;
          dload       = ramload;
          state_nxt_s = IDLE;
        end else if (expired_s) begin
          dwait       = 1'b0;
          timeout_err = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DGRANT;
        end
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_nxt_s = IDLE;
        end else if (access_s) begin
          iwait       = 1'b0;
          iload       = ramload;
          state_nxt_s = IDLE;
        end else if (expired_s) begin
          iwait       = 1'b0;
          timeout_err = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = IGRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; watchdog sequence adapts to MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

  localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int BUSY_N = TMO - 1;
`else
  localparam int BUSY_N = 5;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, timeout_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren;
    logic [31:0] ia;
    logic        dren;
    logic        dwen;
    logic [31:0] da;
    logic [31:0] ds;
    logic [31:0] rl;
    logic [1:0]  rs;
    logic [132:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [132:0] act;
  logic [132:0] idle_exp;

  assign act = {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err};

  function automatic logic [132:0] ex(input logic iw, input logic [31:0] il, input logic dw,
                                      input logic [31:0] dl, input logic rr, input logic rw,
                                      input logic [31:0] ra, input logic [31:0] rst_v);
    return {iw, il, dw, dl, rr, rw, ra, rst_v, 1'b0};
  endfunction

  task automatic add(input logic iren, input logic [31:0] ia, input logic dren, input logic dwen,
                     input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                     input logic [1:0] rs, input logic [132:0] e);
    vec_t v;
    v.iren = iren; v.ia = ia; v.dren = dren; v.dwen = dwen;
    v.da = da; v.ds = ds; v.rl = rl; v.rs = rs; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic set_in(input logic iren, input logic [31:0] ia, input logic dren, input logic dwen,
                        input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                        input logic [1:0] rs);
    iREN = iren; iaddr = ia; dREN = dren; dWEN = dwen;
    daddr = da; dstore = ds; ramload = rl; ramstate = rs;
  endtask

  task automatic chk(input string nm, input logic [132:0] a, input logic [132:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, a, e);
    end
  endtask

  initial begin
    idle_exp = ex(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Instruction fetch, abort, data write with pending fetch, read/write collision, back-to-back data.
    add(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        2'd0, idle_exp);
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        32'h2402000A, 2'd0, idle_exp);
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        32'h2402000A, 2'd2,
        ex(1'b0, 32'h2402000A, 1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0));
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        32'h2402000A, 2'd2, idle_exp);
    add(1'b0, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        32'h2402000A, 2'd0,
        ex(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0));
    add(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 32'h0,        2'd0, idle_exp);
    add(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 32'h0,        2'd1,
        ex(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF));
    add(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 32'h0,        2'd3,
        ex(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF));
    add(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 32'h12345678, 2'd2,
        ex(1'b1, 32'h0, 1'b0, 32'h12345678, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF));
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 32'hDEADBEEF, 32'h12345678, 2'd2, idle_exp);
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 32'hDEADBEEF, 32'h0BADF00D, 2'd2,
        ex(1'b0, 32'h0BADF00D, 1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0));
    add(1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h11,       32'h0,        2'd0, idle_exp);
    add(1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h11,       32'hAA,       2'd2,
        ex(1'b1, 32'h0, 1'b0, 32'hAA, 1'b0, 1'b1, 32'h40, 32'h11));
    add(1'b0, 32'h0,   1'b1, 1'b0, 32'h44, 32'h55,       32'h0,        2'd0, idle_exp);
    add(1'b0, 32'h0,   1'b1, 1'b0, 32'h44, 32'h55,       32'h0,        2'd1,
        ex(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h44, 32'h55));
    add(1'b0, 32'h0,   1'b1, 1'b0, 32'h44, 32'h55,       32'h77,       2'd2,
        ex(1'b1, 32'h0, 1'b0, 32'h77, 1'b1, 1'b0, 32'h44, 32'h55));
    add(1'b1, 32'h100, 1'b1, 1'b0, 32'h44, 32'h55,       32'h77,       2'd2, idle_exp);
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h44, 32'h55,       32'h77,       2'd2,
        ex(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h44, 32'h55));
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h44, 32'h55,       32'h0,        2'd0, idle_exp);
    add(1'b0, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        2'd0,
        ex(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0));

    // Reset holds IDLE outputs even with every request active and RAM reporting ACCESS.
    RST = 1'b1;
    set_in(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h1, 32'hFFFFFFFF, 2'd2);
    #2;
    chk("reset_idle", act, idle_exp);
    @(negedge CLK);
    RST = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      set_in(tbl[i].iren, tbl[i].ia, tbl[i].dren, tbl[i].dwen, tbl[i].da, tbl[i].ds, tbl[i].rl, tbl[i].rs);
      #1;
      chk($sformatf("row%0d", i), act, tbl[i].exp);
    end

    // Data grant held BUSY, then request dropped: abort without completion.
    @(negedge CLK);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h5A5A5A5A, 2'd1);
    for (int k = 0; k < BUSY_N; k++) begin
      @(negedge CLK);
      #1;
      chk1($sformatf("busy%0d_dwait", k), dwait, 1'b1);
      chk1($sformatf("busy%0d_ramren", k), ramREN, 1'b1);
    end
    @(negedge CLK);
    dREN = 1'b0;
    #1;
    chk1("abort_dwait", dwait, 1'b1);
    chk1("abort_ramren", ramREN, 1'b0);
    @(negedge CLK);
    dREN = 1'b1;
    ramstate = 2'd2;
    #1;
    chk1("after_abort_dwait", dwait, 1'b1);
    chk1("after_abort_ramren", ramREN, 1'b0);
    @(negedge CLK);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
    @(negedge CLK);

    // Asynchronous reset in the middle of an instruction grant.
    set_in(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd1);
    @(negedge CLK);
    #1;
    chk1("igrant_ramren", ramREN, 1'b1);
    #1;
    RST = 1'b1;
    iREN = 1'b0;
    #1;
    chk1("rst_mid_ramren", ramREN, 1'b0);
    chk1("rst_mid_iwait", iwait, 1'b1);
    chk("rst_mid_all", act, idle_exp);
    #1;
    RST = 1'b0;

    // Watchdog behaviour on a stuck data read.
    @(negedge CLK);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0, 32'hFFFFFFFF, 2'd1);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int g = 1; g <= TMO; g++) begin
      @(negedge CLK);
      #1;
      if (g < TMO) begin
        chk1($sformatf("wd_g%0d_dwait", g), dwait, 1'b1);
        chk1($sformatf("wd_g%0d_terr", g), timeout_err, 1'b0);
      end else begin
        chk1("wd_fire_dwait", dwait, 1'b0);
        chk("wd_fire_dload", {101'h0, dload}, 133'h0);
        chk1("wd_fire_terr", timeout_err, 1'b1);
      end
    end
    @(negedge CLK);
    #1;
    chk1("wd_after_dwait", dwait, 1'b1);
    chk1("wd_after_ramren", ramREN, 1'b0);
    chk1("wd_after_terr", timeout_err, 1'b0);
`else
    for (int g = 1; g <= 2 * TMO; g++) begin
      @(negedge CLK);
      #1;
      chk1($sformatf("nowd_g%0d_dwait", g), dwait, 1'b1);
      chk1($sformatf("nowd_g%0d_terr", g), timeout_err, 1'b0);
    end
`endif
    @(negedge CLK);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the number of grant-state cycles without RAM ACCESS before the watchdog fires.
REQ-002 SHALL have ports CLK in 1, the single clock, and RST in 1, the asynchronous active-high reset.
REQ-003 SHALL have ports iREN in 1 (instruction read request), iaddr in 32 (instruction address), iwait out 1 (instruction stall), iload out 32 (instruction data).
REQ-004 SHALL have ports dREN in 1, dWEN in 1, daddr in 32, dstore in 32, dwait out 1, dload out 32, all on the data side.
REQ-005 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32, ramload in 32, ramstate in 2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-006 SHALL have port timeout_err out 1, a one-cycle watchdog pulse.

Function
REQ-007 SHALL implement the FSM states IDLE, DGRANT and IGRANT, held in a registered state variable.
REQ-008 IDLE: if dREN or dWEN, next state DGRANT; else if iREN, next state IGRANT; else stay IDLE. Data has fixed priority over instructions.
REQ-009 In IDLE, all ram* outputs SHALL be 0, and iwait=1 and dwait=1.
REQ-010 In DGRANT, ramaddr=daddr and ramstore=dstore; if dWEN, ramWEN=1 and ramREN=0; else ramREN=dREN. Write wins when dREN and dWEN are both high.
REQ-011 In IGRANT, ramREN=1, ramWEN=0, ramaddr=iaddr, and ramstore=0.
REQ-012 In a grant state with ramstate==ACCESS, the granted wait SHALL be 0 for exactly that cycle, the granted load SHALL equal ramload combinationally, and the next state SHALL be IDLE.
REQ-013 ramstate BUSY or FREE SHALL hold the grant with wait=1; ramstate ERROR SHALL be treated as BUSY.
REQ-014 The non-granted side SHALL see wait=1 and load=0 at all times.
REQ-015 If the granted requester drops its request mid-grant, the next state SHALL be IDLE with no wait deassertion (abort).
REQ-016 Minimum latency from request to wait=0 SHALL be 2 cycles: one IDLE cycle, then a grant cycle with ACCESS.
REQ-017 Back-to-back data requests SHALL pass through IDLE between them, giving a pending iREN no starvation guarantee (documented limitation).
REQ-018 dload and iload SHALL be 0 whenever their wait is 1.

Reset
REQ-019 RST high SHALL asynchronously force state=IDLE, the timeout counter to 0, and timeout_err=0, so outputs take their IDLE values immediately.
REQ-020 Reset asserted mid-grant SHALL drop ramREN/ramWEN in the same cycle, with no completion signalled.

Configuration
REQ-021 Macro MEM_ARB_TIMEOUT_EN defined: a counter SHALL increment each grant cycle without ACCESS and clear on entering IDLE.
REQ-022 When that count reaches TIMEOUT_CYCLES-1, the granted wait SHALL go 0 with load 0, timeout_err SHALL pulse for 1 cycle, and the next state SHALL be IDLE.
REQ-023 Macro undefined: no counter SHALL be built, timeout_err SHALL be tied 0, and grants SHALL wait indefinitely.

Structure
REQ-024 word_t, ramstate_t (FREE/BUSY/ACCESS/ERROR) and arb_state_t SHALL live in cpu_types_pkg.
REQ-025 The watchdog counter SHALL be the sub-module arb_timer (ports: CLK, RST, en, clr, expired), instantiated only under MEM_ARB_TIMEOUT_EN.
REQ-026 All other logic SHALL be flat in mem_arbiter, with no latches and a single always_ff for state.

Verification
REQ-027 iREN=1, iaddr=0x100, ACCESS on the 2nd cycle, ramload=0x2402000A -> iwait=0 and iload=0x2402000A in cycle 2, state IDLE in cycle 3.
REQ-028 dWEN=1 and iREN=1 together, daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF, iwait stays 1 until the data side completes.
REQ-029 dREN=1 and dWEN=1, daddr=0x40 -> ramWEN=1 and ramREN=0.
REQ-030 DGRANT with ramstate=BUSY for 5 cycles, then dREN dropped -> next state IDLE, dwait never 0.
REQ-031 RST pulsed during IGRANT -> ramREN=0 in the same cycle and iwait=1.
REQ-032 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, dREN held with ramstate=BUSY -> dwait=0, dload=0 and timeout_err=1 in the 4th grant cycle; without the macro, dwait stays 1.
